// File: rtl/mpcg_pkg.sv
// Shared types and helpers for the multi-phase clock generator.
// State encoding, minimum slot length and the phase-window test.
package mpcg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 1;

  // True when a channel starting at `phase` is high during `slot`.
  // slots is a power of two, so masking gives the modular distance.
  function automatic logic slot_in_window(
    input int unsigned slot,
    input int unsigned phase,
    input int unsigned slots
  );
    int unsigned d;
    d = (slot - phase) & (slots - 1);
    return d < (slots >> 1);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Slot timebase: q_cnt counts clk cycles within a slot, slot counts slots.
// Ports: clk, rst, run (advance enable, cleared when low), div (cycles per
// slot), per_cnt, q_wrap, slot_nxt, period_end.
module slot_counter
  import mpcg_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [CNT_W-1:0]  div,
  output logic [CNT_W-1:0]  per_cnt,
  output logic              q_wrap,
  output logic [SLOT_W-1:0] slot_nxt,
  output logic              period_end
);

  logic [CNT_W-1:0]  q_cnt;
  logic [SLOT_W-1:0] slot;

  always_comb begin
    q_wrap     = (q_cnt == div - CNT_W'(MIN_DIV));
    slot_nxt   = q_wrap ? slot + SLOT_W'(1) : slot;
    period_end = q_wrap && (slot == SLOT_W'(SLOTS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      q_cnt   <= '0;
      slot    <= '0;
      per_cnt <= '0;
    end else begin
      q_cnt <= q_wrap ? '0 : q_cnt + CNT_W'(1);
      slot  <= slot_nxt;
      if (period_end)
        per_cnt <= per_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multiphase_clk_gen.sv
// N-channel multi-phase clock generator with burst and graceful stop.
// Ports: clk, rst, start, stop, div_q, nper, phase, idle_lvl -> clk_out,
// busy, done, period_tick.
module multiphase_clk_gen
  import mpcg_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SLOT_W = $clog2(SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_W-1:0]      div_q,
  input  logic [CNT_W-1:0]      nper,
  input  logic [NCH*SLOT_W-1:0] phase,
  input  logic [NCH-1:0]        idle_lvl,
  output logic [NCH-1:0]        clk_out,
  output logic                  busy,
  output logic                  done,
  output logic                  period_tick
);

  state_t                state;
  logic [CNT_W-1:0]      div_sh;
  logic [CNT_W-1:0]      nper_sh;
  logic [NCH*SLOT_W-1:0] phase_sh;
  logic                  stop_pend;

  logic [CNT_W-1:0]  per_cnt;
  logic              q_wrap;
  logic [SLOT_W-1:0] slot_nxt;
  logic              period_end;

  logic [NCH-1:0] wave_nxt;
  logic [NCH-1:0] wave_first;
  logic           stop_now;
  logic           burst_done;
  logic           finish;

  slot_counter #(
    .CNT_W (CNT_W),
    .SLOTS (SLOTS),
    .SLOT_W(SLOT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .run       (state == RUN),
    .div       (div_sh),
    .per_cnt   (per_cnt),
    .q_wrap    (q_wrap),
    .slot_nxt  (slot_nxt),
    .period_end(period_end)
  );

  // Outputs are registered from the counter's next slot so that
  // clk_out lines up with the slot the counter is entering.
  always_comb begin
    wave_nxt   = '0;
    wave_first = '0;
    for (int k = 0; k < NCH; k++) begin
      wave_nxt[k] = slot_in_window(
        32'(slot_nxt),
        32'(phase_sh[k*SLOT_W +: SLOT_W]),
        SLOTS);
      wave_first[k] = slot_in_window(
        32'd0,
        32'(phase[k*SLOT_W +: SLOT_W]),
        SLOTS);
    end
    stop_now   = stop_pend | stop;
    burst_done = (nper_sh != '0) &&
                 (per_cnt + CNT_W'(1) == nper_sh);
    finish     = period_end && (stop_now || burst_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_out     <= idle_lvl;
      busy        <= 1'b0;
      done        <= 1'b0;
      period_tick <= 1'b0;
      stop_pend   <= 1'b0;
      div_sh      <= '0;
      nper_sh     <= '0;
      phase_sh    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          clk_out     <= idle_lvl;
          done        <= 1'b0;
          period_tick <= 1'b0;
          stop_pend   <= 1'b0;
          if (start && !stop) begin
            state       <= RUN;
            busy        <= 1'b1;
            period_tick <= 1'b1;
            clk_out     <= wave_first;
            div_sh      <= (div_q == '0) ? CNT_W'(MIN_DIV) : div_q;
            nper_sh     <= nper;
            phase_sh    <= phase;
          end
        end
        RUN: begin
          if (finish) begin
            state       <= IDLE;
            clk_out     <= idle_lvl;
            busy        <= 1'b0;
            done        <= 1'b1;
            period_tick <= 1'b0;
            stop_pend   <= 1'b0;
          end else begin
            clk_out     <= wave_nxt;
            done        <= 1'b0;
            period_tick <= q_wrap && (slot_nxt == '0);
            stop_pend   <= stop_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Self-checking bench for multiphase_clk_gen: directed scenarios plus
// random stimulus, checked against an elapsed-cycle reference model.
module tb_multiphase_clk_gen;

  localparam int NCH    = 2;
  localparam int SLOTS  = 4;
  localparam int CNT_W  = 16;
  localparam int SLOT_W = 2;
  localparam int PH_W   = NCH * SLOT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  div_q;
  logic [CNT_W-1:0]  nper;
  logic [PH_W-1:0]   phase;
  logic [NCH-1:0]    idle_lvl;
  logic [NCH-1:0]    clk_out;
  logic              busy;
  logic              done;
  logic              period_tick;

  int vectors = 0;
  int miscompares = 0;
  int n_busy, n_done, n_tick;

  // Reference model state: elapsed cycles since the run began.
  bit             m_run;
  int             m_e;
  int             m_div;
  int             m_nper;
  int             m_ph[NCH];
  bit             m_pend;
  logic [NCH-1:0] m_out;
  logic           m_busy, m_done, m_tick;

  multiphase_clk_gen #(
    .NCH  (NCH),
    .SLOTS(SLOTS),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .div_q      (div_q),
    .nper       (nper),
    .phase      (phase),
    .idle_lvl   (idle_lvl),
    .clk_out    (clk_out),
    .busy       (busy),
    .done       (done),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] wave(input int e);
    logic [NCH-1:0] w;
    int s, d;
    s = (e / m_div) % SLOTS;
    for (int k = 0; k < NCH; k++) begin
      d = (s - m_ph[k] + SLOTS) % SLOTS;
      w[k] = (d < SLOTS / 2);
    end
    return w;
  endfunction

  task automatic model(
    input logic r, input logic st, input logic sp,
    input logic [CNT_W-1:0] dq, input logic [CNT_W-1:0] np,
    input logic [PH_W-1:0] ph, input logic [NCH-1:0] il
  );
    int plen;
    bit pend_now;
    if (r) begin
      m_run = 0; m_e = 0; m_pend = 0;
      m_out = il; m_busy = 0; m_done = 0; m_tick = 0;
    end else if (!m_run) begin
      m_out = il; m_done = 0; m_tick = 0; m_pend = 0;
      if (st && !sp) begin
        m_run  = 1;
        m_e    = 0;
        m_div  = (dq == 0) ? 1 : int'(dq);
        m_nper = int'(np);
        for (int k = 0; k < NCH; k++)
          m_ph[k] = int'(ph[k*SLOT_W +: SLOT_W]);
        m_out  = wave(0);
        m_busy = 1;
        m_tick = 1;
      end
    end else begin
      plen = m_div * SLOTS;
      pend_now = m_pend | sp;
      if (((m_e + 1) % plen == 0) &&
          (pend_now || (m_nper != 0 && (m_e + 1) / plen == m_nper))) begin
        m_run = 0; m_pend = 0;
        m_out = il; m_busy = 0; m_done = 1; m_tick = 0;
      end else begin
        m_e    = m_e + 1;
        m_pend = pend_now;
        m_out  = wave(m_e);
        m_tick = (m_e % plen == 0);
        m_done = 0;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic r, st, sp;
    logic [CNT_W-1:0] dq, np;
    logic [PH_W-1:0] ph;
    logic [NCH-1:0] il;
    r = rst; st = start; sp = stop;
    dq = div_q; np = nper; ph = phase; il = idle_lvl;
    @(posedge clk);
    model(r, st, sp, dq, np, ph, il);
    #1;
    chk("clk_out", 32'(clk_out), 32'(m_out));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("period_tick", 32'(period_tick), 32'(m_tick));
    n_busy += int'(busy);
    n_done += int'(done);
    n_tick += int'(period_tick);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_counts();
    n_busy = 0; n_done = 0; n_tick = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0;
    div_q = 10; nper = 0; phase = {2'd1, 2'd0};
    idle_lvl = 2'b10;
    m_run = 0; m_div = 1; m_e = 0; m_pend = 0;
    foreach (m_ph[k]) m_ph[k] = 0;
    clr_counts();
    steps(2);
    rst = 0;
    steps(3);
    chk("reset_idle", 32'(clk_out), 32'h2);
    chk("reset_busy", 32'(busy), 32'h0);

    // Legacy quadrature: div 10, ch0 phase 0, ch1 phase 1.
    clr_counts();
    start = 1;
    step();
    start = 0;
    chk("legacy_slot0", 32'(clk_out), 32'h1);
    steps(10);
    chk("legacy_slot1", 32'(clk_out), 32'h3);
    steps(10);
    chk("legacy_slot2", 32'(clk_out), 32'h2);
    steps(100);
    chk("legacy_ticks", 32'(n_tick), 32'd4);

    // Graceful stop raised during slot 1 of a period.
    steps(12);
    stop = 1;
    step();
    stop = 0;
    clr_counts();
    steps(40);
    chk("stop_busy", 32'(n_busy), 32'd26);
    chk("stop_done", 32'(n_done), 32'd1);
    chk("stop_idle", 32'(clk_out), 32'h2);

    // Burst of two periods at div 3.
    div_q = 3; nper = 2; phase = {2'd2, 2'd1}; idle_lvl = 2'b01;
    clr_counts();
    start = 1;
    step();
    start = 0;
    steps(39);
    chk("burst_busy", 32'(n_busy), 32'd24);
    chk("burst_done", 32'(n_done), 32'd1);
    chk("burst_ticks", 32'(n_tick), 32'd2);

    // div_q 0 runs as 1; mid-run input changes are ignored.
    div_q = 0; nper = 0; phase = {2'd0, 2'd3};
    start = 1;
    step();
    start = 0;
    div_q = 7; phase = {2'd2, 2'd2}; nper = 1;
    steps(12);
    stop = 1;
    step();
    stop = 0;
    steps(8);
    chk("div0_stopped", 32'(busy), 32'h0);

    // Reset mid-period at slot 2, q_cnt 5.
    div_q = 8; nper = 0; phase = {2'd1, 2'd0}; idle_lvl = 2'b11;
    start = 1;
    step();
    start = 0;
    steps(21);
    clr_counts();
    rst = 1;
    step();
    rst = 0;
    chk("rst_out", 32'(clk_out), 32'h3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(n_done), 32'd0);
    start = 1;
    step();
    start = 0;
    chk("restart_tick", 32'(period_tick), 32'h1);
    steps(5);
    stop = 1;
    step();
    stop = 0;
    steps(70);

    // start and stop together in IDLE: no run.
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    chk("startstop_idle", 32'(busy), 32'h0);

    // start held during a burst run.
    div_q = 2; nper = 3;
    clr_counts();
    start = 1;
    steps(10);
    start = 0;
    steps(30);
    chk("held_busy", 32'(n_busy), 32'd24);
    chk("held_done", 32'(n_done), 32'd1);

    // Random stimulus.
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(199) == 0);
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(39) == 0);
      if ($urandom_range(9) == 0) div_q = CNT_W'($urandom_range(4));
      if ($urandom_range(9) == 0) nper = CNT_W'($urandom_range(3));
      if ($urandom_range(9) == 0) phase = PH_W'($urandom);
      if ($urandom_range(9) == 0) idle_lvl = NCH'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
